// File: rtl/uart_boot_loader.sv
// UART command-frame boot loader: parses WRITE/READ/RUN/HALT frames,
// performs single-word RAM accesses and gates the core reset.
module uart_boot_loader #(
  parameter int unsigned TIMEOUT_CYCLES = 100000,
  parameter logic [7:0]  SYNC_BYTE      = 8'h55
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        mem_en,
  output logic [3:0]  mem_we,
  output logic [4:0]  mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  output logic        core_hold,
  output logic        frame_err
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [TW-1:0] TMO_ONE  = TW'(1);

  localparam logic [7:0] ACK      = 8'h06;
  localparam logic [7:0] NAK      = 8'h15;
  localparam logic [7:0] CMD_WR   = 8'h01;
  localparam logic [7:0] CMD_RD   = 8'h02;
  localparam logic [7:0] CMD_RUN  = 8'h03;
  localparam logic [7:0] CMD_HALT = 8'h04;

  typedef enum logic [3:0] {
    S_IDLE, S_CMD, S_ADDR, S_DATA, S_CSUM,
    S_EXEC, S_RD_WAIT, S_RESP, S_RESP_DATA
  } state_t;

  state_t        r_state, w_next;
  logic [7:0]    r_cmd, r_addr, r_csum;
  logic [31:0]   r_data, r_rdbuf;
  logic [1:0]    r_idx;
  logic [TW-1:0] r_tmo;
  logic          r_nak, r_core_hold, r_frame_err;
  logic [7:0]    r_tx_data;
  logic          r_tx_valid;

  logic w_rx_st, w_frame_st, w_rx_xfer, w_tx_xfer;
  logic w_tmo, w_cmd_ok, w_is_mem, w_nak, w_rd_ok;

  assign w_rx_st    = (r_state == S_IDLE) || w_frame_st;
  assign w_frame_st = (r_state == S_CMD) || (r_state == S_ADDR) ||
                      (r_state == S_DATA) || (r_state == S_CSUM);
  assign rx_ready   = w_rx_st && !reset;
  assign w_rx_xfer  = rx_valid && rx_ready;
  assign w_tx_xfer  = r_tx_valid && tx_ready;
  assign w_tmo      = w_frame_st && !w_rx_xfer && (r_tmo == TMO_LAST);

  assign w_cmd_ok = (r_cmd >= CMD_WR) && (r_cmd <= CMD_HALT);
  assign w_is_mem = (r_cmd == CMD_WR) || (r_cmd == CMD_RD);
  // Evaluated while the checksum byte itself is on rx_data.
  assign w_nak = ((r_csum ^ rx_data) != 8'h00) || !w_cmd_ok ||
                 (r_addr[7:5] != 3'b000) ||
                 (w_is_mem && !r_core_hold);
  assign w_rd_ok = !r_nak && (r_cmd == CMD_RD);

  assign mem_en    = (r_state == S_EXEC) && !r_nak && w_is_mem;
  assign mem_we    = (mem_en && r_cmd == CMD_WR) ? 4'hF : 4'h0;
  assign mem_addr  = r_addr[4:0];
  assign mem_wdata = r_data;
  assign tx_data   = r_tx_data;
  assign tx_valid  = r_tx_valid;
  assign core_hold = r_core_hold;
  assign frame_err = r_frame_err;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:
        if (w_rx_xfer && rx_data == SYNC_BYTE) w_next = S_CMD;
      S_CMD:
        if (w_tmo)          w_next = S_IDLE;
        else if (w_rx_xfer) w_next = S_ADDR;
      S_ADDR:
        if (w_tmo)          w_next = S_IDLE;
        else if (w_rx_xfer)
          w_next = (r_cmd == CMD_WR) ? S_DATA : S_CSUM;
      S_DATA:
        if (w_tmo) w_next = S_IDLE;
        else if (w_rx_xfer && r_idx == 2'd3) w_next = S_CSUM;
      S_CSUM:
        if (w_tmo)          w_next = S_IDLE;
        else if (w_rx_xfer) w_next = S_EXEC;
      S_EXEC:
        w_next = w_rd_ok ? S_RD_WAIT : S_RESP;
      S_RD_WAIT:
        w_next = S_RESP;
      S_RESP:
        if (w_tx_xfer) w_next = w_rd_ok ? S_RESP_DATA : S_IDLE;
      S_RESP_DATA:
        if (w_tx_xfer && r_idx == 2'd3) w_next = S_IDLE;
      default:
        w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cmd       <= '0;
      r_addr      <= '0;
      r_csum      <= '0;
      r_data      <= '0;
      r_rdbuf     <= '0;
      r_idx       <= '0;
      r_tmo       <= '0;
      r_nak       <= 1'b0;
      r_core_hold <= 1'b1;
      r_frame_err <= 1'b0;
      r_tx_data   <= '0;
      r_tx_valid  <= 1'b0;
    end else begin
      r_frame_err <= w_tmo;
      if (!w_frame_st || w_rx_xfer || w_tmo) r_tmo <= '0;
      else                                   r_tmo <= r_tmo + TMO_ONE;
      unique case (r_state)
        S_IDLE:
          if (w_rx_xfer && rx_data == SYNC_BYTE) begin
            r_csum <= '0;
            r_idx  <= '0;
          end
        S_CMD:
          if (w_rx_xfer) begin
            r_cmd  <= rx_data;
            r_csum <= r_csum ^ rx_data;
          end
        S_ADDR:
          if (w_rx_xfer) begin
            r_addr <= rx_data;
            r_csum <= r_csum ^ rx_data;
          end
        S_DATA:
          if (w_rx_xfer) begin
            r_data <= {rx_data, r_data[31:8]};
            r_csum <= r_csum ^ rx_data;
            r_idx  <= r_idx + 2'd1;
          end
        S_CSUM:
          if (w_rx_xfer) r_nak <= w_nak;
        S_EXEC:
          if (r_nak) begin
            r_tx_data  <= NAK;
            r_tx_valid <= 1'b1;
          end else begin
            if (r_cmd == CMD_RUN)  r_core_hold <= 1'b0;
            if (r_cmd == CMD_HALT) r_core_hold <= 1'b1;
            if (r_cmd != CMD_RD) begin
              r_tx_data  <= ACK;
              r_tx_valid <= 1'b1;
            end
          end
        S_RD_WAIT: begin
          r_rdbuf    <= mem_rdata;
          r_tx_data  <= ACK;
          r_tx_valid <= 1'b1;
        end
        S_RESP:
          if (w_tx_xfer) begin
            if (w_rd_ok) begin
              r_tx_data <= r_rdbuf[7:0];
              r_rdbuf   <= {8'h00, r_rdbuf[31:8]};
              r_idx     <= '0;
            end else begin
              r_tx_valid <= 1'b0;
            end
          end
        S_RESP_DATA:
          if (w_tx_xfer) begin
            r_idx <= r_idx + 2'd1;
            if (r_idx == 2'd3) begin
              r_tx_valid <= 1'b0;
            end else begin
              r_tx_data <= r_rdbuf[7:0];
              r_rdbuf   <= {8'h00, r_rdbuf[31:8]};
            end
          end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_boot_loader.sv
// Randomised bench for uart_boot_loader with a frame-level reference
// model, a 32-word RAM and a handshake-stall receiver.
module tb_uart_boot_loader;

  localparam int TMO = 16;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [7:0]  rx_data = '0;
  logic        rx_valid = 1'b0;
  logic        rx_ready;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready = 1'b0;
  logic        mem_en;
  logic [3:0]  mem_we;
  logic [4:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata = '0;
  logic        core_hold;
  logic        frame_err;

  always #5 clk = ~clk;

  uart_boot_loader #(
    .TIMEOUT_CYCLES(TMO),
    .SYNC_BYTE(8'h55)
  ) dut (
    .clk(clk),
    .reset(reset),
    .rx_data(rx_data),
    .rx_valid(rx_valid),
    .rx_ready(rx_ready),
    .tx_data(tx_data),
    .tx_valid(tx_valid),
    .tx_ready(tx_ready),
    .mem_en(mem_en),
    .mem_we(mem_we),
    .mem_addr(mem_addr),
    .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata),
    .core_hold(core_hold),
    .frame_err(frame_err)
  );

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0] ram[32];
  logic [31:0] ref_mem[32];
  bit          ref_hold = 1'b1;

  int          en_cnt = 0, wr_cnt = 0, ferr_cnt = 0, bad_we = 0;
  logic [4:0]  wr_addr = '0;
  logic [31:0] wr_data = '0;

  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we == 4'hF) ram[mem_addr] <= mem_wdata;
      mem_rdata <= ram[mem_addr];
    end
  end

  always @(negedge clk) begin
    if (frame_err) ferr_cnt++;
    if (mem_en) begin
      en_cnt++;
      if (mem_we == 4'hF) begin
        wr_cnt++;
        wr_addr = mem_addr;
        wr_data = mem_wdata;
      end else if (mem_we != 4'h0) begin
        bad_we++;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    rx_data  = b;
    rx_valid = 1'b1;
    while (!rx_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!rx_ready) chk("rx_wait", 32'(rx_ready), 32'd1);
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic recv_byte(output logic [7:0] b, input int stall);
    int n = 0;
    logic [7:0] held;
    b = '0;
    tx_ready = 1'b0;
    while (!tx_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!tx_valid) begin
      chk("tx_wait", 32'(tx_valid), 32'd1);
      return;
    end
    held = tx_data;
    repeat (stall) begin
      @(negedge clk);
      chk("tx_hold_valid", 32'(tx_valid), 32'd1);
      chk("tx_hold_data", 32'(tx_data), 32'(held));
    end
    b = tx_data;
    tx_ready = 1'b1;
    @(negedge clk);
    tx_ready = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset    = 1'b1;
    rx_valid = 1'b0;
    tx_ready = 1'b0;
    #1;
    chk("rst_rx_ready", 32'(rx_ready), 32'd0);
    chk("rst_tx_valid", 32'(tx_valid), 32'd0);
    chk("rst_tx_data", 32'(tx_data), 32'd0);
    chk("rst_mem_en", 32'(mem_en), 32'd0);
    chk("rst_mem_we", 32'(mem_we), 32'd0);
    chk("rst_mem_addr", 32'(mem_addr), 32'd0);
    chk("rst_mem_wdata", mem_wdata, 32'd0);
    chk("rst_frame_err", 32'(frame_err), 32'd0);
    chk("rst_core_hold", 32'(core_hold), 32'd1);
    ref_hold = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic run_frame(input logic [7:0] cmd, input logic [7:0] addr,
                           input logic [31:0] data, input logic [7:0] cerr,
                           input int garb, input int stall, input int gap);
    logic [7:0] q[$];
    logic [7:0] exp[$];
    logic [7:0] cs, b;
    bit nak;
    int en0, wr0, fe0, exp_en;
    q = {cmd, addr};
    cs = cmd ^ addr;
    if (cmd == 8'h01)
      for (int i = 0; i < 4; i++) begin
        q.push_back(data[8*i +: 8]);
        cs ^= data[8*i +: 8];
      end
    q.push_back(cs ^ cerr);

    nak = (cerr != 0) || (cmd == 0) || (cmd > 4) || (addr > 31) ||
          ((cmd == 1 || cmd == 2) && !ref_hold);
    exp_en = 0;
    if (nak) begin
      exp.push_back(8'h15);
    end else begin
      exp.push_back(8'h06);
      case (cmd)
        8'h01: begin ref_mem[addr[4:0]] = data; exp_en = 1; end
        8'h02: begin
          for (int i = 0; i < 4; i++)
            exp.push_back(ref_mem[addr[4:0]][8*i +: 8]);
          exp_en = 1;
        end
        8'h03: ref_hold = 1'b0;
        default: ref_hold = 1'b1;
      endcase
    end

    en0 = en_cnt; wr0 = wr_cnt; fe0 = ferr_cnt;
    repeat (garb) begin
      b = 8'($urandom);
      if (b == 8'h55) b = 8'hAA;
      send_byte(b);
    end
    send_byte(8'h55);
    foreach (q[i]) begin
      repeat ($urandom_range(0, gap)) @(negedge clk);
      send_byte(q[i]);
    end
    foreach (exp[i]) begin
      recv_byte(b, stall);
      chk("tx_byte", 32'(b), 32'(exp[i]));
    end
    chk("tx_idle", 32'(tx_valid), 32'd0);
    chk("mem_en_cnt", 32'(en_cnt - en0), 32'(exp_en));
    if (cmd == 8'h01 && !nak) begin
      chk("wr_cnt", 32'(wr_cnt - wr0), 32'd1);
      chk("wr_addr", 32'(wr_addr), 32'(addr[4:0]));
      chk("wr_data", wr_data, data);
    end else begin
      chk("wr_cnt", 32'(wr_cnt - wr0), 32'd0);
    end
    chk("core_hold", 32'(core_hold), 32'(ref_hold));
    chk("frame_err_none", 32'(ferr_cnt - fe0), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, en0, u, stall;
    logic [7:0] b, cmd, addr, cerr;
    for (int i = 0; i < 32; i++) begin
      ram[i]     = $urandom;
      ref_mem[i] = ram[i];
    end
    do_reset();

    run_frame(8'h01, 8'h03, 32'hDEADBEEF, 8'h00, 0, 0, 0);
    run_frame(8'h02, 8'h03, 32'h0, 8'h00, 0, 5, 0);
    run_frame(8'h01, 8'h03, 32'hDEADBEEF, 8'h01, 0, 0, 0);
    run_frame(8'h02, 8'h20, 32'h0, 8'h00, 0, 0, 0);
    run_frame(8'h03, 8'h00, 32'h0, 8'h00, 0, 0, 0);
    run_frame(8'h01, 8'h05, 32'h12345678, 8'h00, 0, 0, 0);
    run_frame(8'h04, 8'h00, 32'h0, 8'h00, 0, 0, 0);

    en0 = en_cnt;
    send_byte(8'h55);
    send_byte(8'h01);
    n = 0;
    while (!frame_err && n < 100) begin
      @(negedge clk);
      n++;
      if (tx_valid) chk("tmo_no_tx", 32'(tx_valid), 32'd0);
    end
    chk("tmo_cycles", 32'(n), 32'(TMO));
    @(negedge clk);
    chk("tmo_pulse", 32'(frame_err), 32'd0);
    chk("tmo_no_mem", 32'(en_cnt - en0), 32'd0);
    ferr_cnt = 0;
    run_frame(8'h02, 8'h03, 32'h0, 8'h00, 0, 1, 0);

    run_frame(8'h03, 8'h00, 32'h0, 8'h00, 0, 0, 0);
    send_byte(8'h55);
    send_byte(8'h01);
    send_byte(8'h03);
    send_byte(8'hEF);
    do_reset();
    run_frame(8'h01, 8'h07, 32'hCAFEF00D, 8'h00, 0, 0, 1);

    send_byte(8'h55);
    send_byte(8'h02);
    send_byte(8'h07);
    send_byte(8'h05);
    recv_byte(b, 0);
    chk("rd_ack_pre_rst", 32'(b), 32'h06);
    recv_byte(b, 2);
    chk("rd_b0_pre_rst", 32'(b), 32'h0D);
    do_reset();
    run_frame(8'h02, 8'h07, 32'h0, 8'h00, 0, 0, 0);

    for (int k = 0; k < 80; k++) begin
      u    = $urandom_range(0, 99);
      cmd  = (u < 35) ? 8'h01 : (u < 70) ? 8'h02 :
             (u < 80) ? 8'h03 : (u < 90) ? 8'h04 :
             8'($urandom_range(5, 255));
      if ($urandom_range(0, 9) == 0) cmd = 8'h00;
      addr = ($urandom_range(0, 9) == 0) ? 8'($urandom_range(32, 255))
                                         : 8'($urandom_range(0, 31));
      cerr = ($urandom_range(0, 9) == 0) ? 8'($urandom_range(1, 255))
                                         : 8'h00;
      stall = $urandom_range(0, 3);
      run_frame(cmd, addr, $urandom, cerr, $urandom_range(0, 2), stall, 3);
    end
    chk("mem_we_legal", 32'(bad_we), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
